// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_TRAP,
    SRC_EX,
    SRC_ID
  } redir_src_e;

  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP          = 32'h0000_0013;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus between the fetch sequencer
// (master) and the instruction memory (slave).
interface fetch_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_rsp_valid;
  logic [WIDTH-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_sequencer_redirect_prio_sel.sv
// Fixed-priority redirect selector: trap > EX branch > ID jump.
// The winning target is word-aligned by clearing bits [1:0].
module redirect_prio_sel
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_target,
  input  logic             ex_redir_valid,
  input  logic [WIDTH-1:0] ex_redir_target,
  input  logic             id_jump_valid,
  input  logic [WIDTH-1:0] id_jump_target,
  output logic             redir,
  output logic [WIDTH-1:0] target
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  redir_src_e       src;
  logic [WIDTH-1:0] raw_target;

  // Pick the highest-priority active source.
  always_comb begin
    if (trap_valid)          src = SRC_TRAP;
    else if (ex_redir_valid) src = SRC_EX;
    else if (id_jump_valid)  src = SRC_ID;
    else                     src = SRC_NONE;
  end

  // Route the winner's target; losers in the same cycle are dropped.
  always_comb begin
    case (src)
      SRC_TRAP: raw_target = trap_target;
      SRC_EX:   raw_target = ex_redir_target;
      SRC_ID:   raw_target = id_jump_target;
      default:  raw_target = '0;
    endcase
  end

  assign redir  = (src != SRC_NONE);
  assign target = raw_target & ALIGN_MASK;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: drives PC stall/redirect, issues one
// outstanding imem request at a time, drops stale responses after a
// redirect and holds the fetched instruction until decode accepts it.
// Optional build macro FETCH_SEQ_PERF_EN adds saturating perf counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(RESET_ADDR_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_stall,
  output logic             pc_take_branch,
  output logic [WIDTH-1:0] pc_branch_target,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_target,
  input  logic             ex_redir_valid,
  input  logic [WIDTH-1:0] ex_redir_target,
  input  logic             id_jump_valid,
  input  logic [WIDTH-1:0] id_jump_target,
  input  logic             pipe_stall,
  fetch_sequencer_if.master imem,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic             if_flush
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_redirects,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_dropped_rsp
`endif
);

  fetch_state_e state;
  logic         drop_q;
  logic         redir;
  logic         redir_take;
  logic         advance;

  redirect_prio_sel #(.WIDTH(WIDTH)) u_prio_sel (
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .ex_redir_valid  (ex_redir_valid),
    .ex_redir_target (ex_redir_target),
    .id_jump_valid   (id_jump_valid),
    .id_jump_target  (id_jump_target),
    .redir           (redir),
    .target          (pc_branch_target)
  );

  // Redirects are ignored only during the boot idle cycle; pipe_stall
  // never blocks them.
  assign redir_take = redir && (state != S_BOOT);
  assign advance    = (state == S_HOLD) && !pipe_stall && !redir;

  assign pc_take_branch      = redir_take;
  assign if_flush            = redir_take;
  assign pc_stall            = !(redir_take || advance);
  assign if_valid            = (state == S_HOLD);
  assign imem.imem_req_valid = (state == S_REQ) && !redir;
  assign imem.imem_req_addr  = pc;

  // Fetch FSM with stale-response drop flag and instruction holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_BOOT;
      drop_q   <= 1'b0;
      if_instr <= '0;
      if_pc    <= RESET_ADDR;
    end else begin
      case (state)
        S_BOOT: state <= S_REQ;
        S_REQ: begin
          if (!redir && imem.imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (!drop_q && !redir) begin
              if_instr <= imem.imem_rsp_data;
              if_pc    <= pc;
              state    <= S_HOLD;
            end else begin
              drop_q <= 1'b0;
              state  <= S_REQ;
            end
          end else if (redir) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redir || !pipe_stall) state <= S_REQ;
        end
        default: state <= S_BOOT;
      endcase
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Event counters, each pinned at all-ones once full.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
      perf_dropped_rsp  <= '0;
    end else begin
      if (redir_take)
        perf_redirects <= sat_inc(perf_redirects);
      if ((state == S_HOLD) && pipe_stall)
        perf_stall_cycles <= sat_inc(perf_stall_cycles);
      if ((state == S_WAIT) && imem.imem_rsp_valid && (drop_q || redir))
        perf_dropped_rsp <= sat_inc(perf_dropped_rsp);
    end
  end
`endif

  // A response may only arrive while a fetch is outstanding.
  a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (reset)
    imem.imem_rsp_valid |-> (state == S_WAIT));

  // A pending request stays up until accepted unless a redirect pulls it.
  a_req_not_retracted: assert property (@(posedge clk) disable iff (reset)
    (imem.imem_req_valid && !imem.imem_req_ready) |=> (imem.imem_req_valid || redir));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios push expected
// requests, deliveries and redirect targets; a negedge monitor pops them.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_stall, pc_take_branch, if_valid, if_flush;
  logic [31:0] pc_branch_target, if_instr, if_pc;
  logic        trap_valid, ex_redir_valid, id_jump_valid, pipe_stall;
  logic [31:0] trap_target, ex_redir_target, id_jump_target;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_redirects, perf_stall_cycles, perf_dropped_rsp;
`endif

  fetch_sequencer_if #(.WIDTH(32)) bus ();

  fetch_sequencer #(.WIDTH(32), .RESET_ADDR(32'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc               (pc),
    .pc_stall         (pc_stall),
    .pc_take_branch   (pc_take_branch),
    .pc_branch_target (pc_branch_target),
    .trap_valid       (trap_valid),
    .trap_target      (trap_target),
    .ex_redir_valid   (ex_redir_valid),
    .ex_redir_target  (ex_redir_target),
    .id_jump_valid    (id_jump_valid),
    .id_jump_target   (id_jump_target),
    .pipe_stall       (pipe_stall),
    .imem             (bus.master),
    .if_valid         (if_valid),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .if_flush         (if_flush)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .perf_redirects   (perf_redirects),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_dropped_rsp (perf_dropped_rsp)
`endif
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          lat     = 1;
  logic [31:0] exp_req[$];
  logic [63:0] exp_if[$];
  logic [31:0] exp_tgt[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [63:0] act);
    n_total++;
    n_bad++;
    $display("FAIL %s: actual=%h required=<nothing queued>", name, act);
  endtask

  // PC register the sequencer steers.
  initial begin : pc_model
    logic [31:0] nxt;
    pc = 32'h0;
    forever begin
      @(negedge clk);
      if (reset)               nxt = 32'h0;
      else if (pc_take_branch) nxt = pc_branch_target;
      else if (!pc_stall)      nxt = pc + 32'd4;
      else                     nxt = pc;
      @(posedge clk);
      #1 pc = nxt;
    end
  end

  // Instruction memory: always ready, answers lat cycles after accept.
  initial begin : imem_model
    logic        acc;
    logic [31:0] addr_l;
    int          left;
    left = 0;
    addr_l = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      acc = bus.imem_req_valid && bus.imem_req_ready && !reset;
      if (acc) addr_l = bus.imem_req_addr;
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (acc) left = lat;
      if (left > 0) begin
        left = left - 1;
        if (left == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = 32'h13 | (addr_l << 12);
        end
      end
    end
  end

  // Scoreboard monitor: requests, deliveries and flush targets.
  initial begin : monitor
    logic [31:0] e32;
    logic [63:0] e64;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          if (exp_req.size() == 0) fail_unexpected("req_addr", {32'h0, bus.imem_req_addr});
          else begin
            e32 = exp_req.pop_front();
            check("req_addr", {32'h0, bus.imem_req_addr}, {32'h0, e32});
          end
        end
        if (if_valid && !pipe_stall && !(trap_valid || ex_redir_valid || id_jump_valid)) begin
          if (exp_if.size() == 0) fail_unexpected("deliver_pc_instr", {if_pc, if_instr});
          else begin
            e64 = exp_if.pop_front();
            check("deliver_pc_instr", {if_pc, if_instr}, e64);
          end
        end
        if (if_flush) begin
          if (exp_tgt.size() == 0) fail_unexpected("flush_target", {32'h0, pc_branch_target});
          else begin
            e32 = exp_tgt.pop_front();
            check("flush_target", {32'h0, pc_branch_target}, {32'h0, e32});
          end
        end
      end
    end
  end

  task automatic wait_accept(output int at_cyc);
    logic found = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        found  = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
    if (!found) fail_unexpected("accept_timeout", 64'h0);
  endtask

  task automatic wait_if_valid();
    logic found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_unexpected("if_valid_timeout", 64'h0);
  endtask

  initial begin : stim
    int t[4];
    int tmp;
    reset = 1'b1;
    pipe_stall = 1'b0;
    trap_valid = 1'b0;      trap_target = 32'h0;
    ex_redir_valid = 1'b0;  ex_redir_target = 32'h0;
    id_jump_valid = 1'b0;   id_jump_target = 32'h0;

    // Straight-line fetch from the reset vector.
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_req.push_back(32'hC);
    exp_if.push_back({32'h0, INSTR_NOP});
    exp_if.push_back({32'h4, 32'h0000_4013});
    exp_if.push_back({32'h8, 32'h0000_8013});
    exp_if.push_back({32'hC, 32'h0000_C013});

    repeat (3) @(posedge clk);
    #1;
    check("rst_if_valid", {63'h0, if_valid}, 64'h0);
    check("rst_if_instr", {32'h0, if_instr}, 64'h0);
    check("rst_if_pc", {32'h0, if_pc}, 64'h0);
    check("rst_if_flush", {63'h0, if_flush}, 64'h0);
    check("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
    check("rst_pc_stall", {63'h0, pc_stall}, 64'h1);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) wait_accept(t[i]);
    for (int i = 1; i < 4; i++) check("accept_spacing", 64'(t[i] - t[i-1]), 64'd3);

    // Decode stall for five cycles while the instruction at 0xC is held.
    @(posedge clk);
    #1 pipe_stall = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold_pc_instr", {if_pc, if_instr}, {32'hC, 32'h0000_C013});
      check("stall_valid_pcstall", {62'h0, if_valid, pc_stall}, 64'h3);
    end
    exp_req.push_back(32'h10);
    @(posedge clk);
    #1;
    pipe_stall = 1'b0;
    lat = 3;
    @(negedge clk);
    check("release_pc_stall", {63'h0, pc_stall}, 64'h0);

    // EX redirect while waiting; the late response must be discarded.
    wait_accept(tmp);
    exp_tgt.push_back(32'h100);
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    exp_if.push_back({32'h100, 32'h0010_0013});
    @(posedge clk);
    #1;
    ex_redir_valid = 1'b1;
    ex_redir_target = 32'h100;
    @(negedge clk);
    check("ex_flush_take_stall", {61'h0, if_flush, pc_take_branch, pc_stall}, 64'h6);
    @(posedge clk);
    #1;
    ex_redir_valid = 1'b0;
    lat = 1;
    wait_accept(tmp);
    wait_accept(tmp);

    // All three sources at once while holding 0x104: trap wins.
    exp_tgt.push_back(32'h80);
    exp_req.push_back(32'h80);
    exp_req.push_back(32'h84);
    exp_if.push_back({32'h80, 32'h0008_0013});
    @(posedge clk);
    @(posedge clk);
    #1;
    trap_valid = 1'b1;     trap_target = 32'h80;
    ex_redir_valid = 1'b1; ex_redir_target = 32'h200;
    id_jump_valid = 1'b1;  id_jump_target = 32'h300;
    @(negedge clk);
    check("prio_target", {32'h0, pc_branch_target}, 64'h80);
    @(posedge clk);
    #1;
    trap_valid = 1'b0;
    ex_redir_valid = 1'b0;
    id_jump_valid = 1'b0;
    wait_accept(tmp);
    wait_accept(tmp);

    // Misaligned ID jump coinciding with the response for 0x84.
    exp_tgt.push_back(32'h100);
    exp_req.push_back(32'h100);
    @(posedge clk);
    #1;
    id_jump_valid = 1'b1;
    id_jump_target = 32'h103;
    @(negedge clk);
    check("align_target", {32'h0, pc_branch_target}, 64'h100);
    @(posedge clk);
    #1;
    id_jump_valid = 1'b0;
    pipe_stall = 1'b1;
    @(negedge clk);
    check("coincide_no_if_valid", {63'h0, if_valid}, 64'h0);
    wait_if_valid();
    check("coincide_refetch", {if_pc, if_instr}, {32'h100, 32'h0010_0013});

    repeat (5) @(negedge clk);
    check("req_queue_drained", 64'(exp_req.size()), 64'h0);
    check("if_queue_drained", 64'(exp_if.size()), 64'h0);
    check("tgt_queue_drained", 64'(exp_tgt.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control block that sequences the program counter and the instruction-memory fetch handshake for the IF stage. It selects among three redirect sources by fixed priority: trap, EX-stage branch, ID-stage jump. It drives the PC's stall, take-branch and target inputs, and issues one outstanding imem request at a time. It discards stale responses after a redirect and holds the fetched instruction until the pipeline accepts it.

Parameters:
WIDTH, 32, address/instruction width
RESET_ADDR, 32'h0000_0000, PC reset vector (matches PC instance)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pc  in  WIDTH  current PC from PC register
pc_stall  out  1  PC hold (1 = hold)
pc_take_branch  out  1  load pc_branch_target
pc_branch_target  out  WIDTH  selected redirect target
trap_valid / trap_target  in  1 / WIDTH  redirect, priority 0 (highest)
ex_redir_valid / ex_redir_target  in  1 / WIDTH  redirect, priority 1
id_jump_valid / id_jump_target  in  1 / WIDTH  redirect, priority 2
pipe_stall  in  1  decode cannot accept instruction
imem_req_valid / imem_req_ready  out / in  1  fetch request handshake
imem_req_addr  out  WIDTH  = pc
imem_rsp_valid / imem_rsp_data  in  1 / WIDTH  fetch response, one per accepted request
if_valid  out  1  if_instr/if_pc valid
if_instr / if_pc  out  WIDTH  held instruction and its address
if_flush  out  1  one-cycle squash of younger stages

Behaviour:
- The interface is one clock, clk. Reset is synchronous and active-high on reset.
- FSM states: S_BOOT, S_REQ, S_WAIT, S_HOLD. Extra flag drop_q.
- Reset: state=S_BOOT, drop_q=0. if_valid=0, if_instr=0, if_pc=RESET_ADDR, if_flush=0, imem_req_valid=0.
- S_BOOT: one idle cycle with pc_stall=1, then S_REQ.
- redir = trap_valid | ex_redir_valid | id_jump_valid.
- Target selection: highest-priority valid source wins; lower sources that cycle are dropped. Target bits [1:0] are forced to 0.
- Redirect cycle, in any state except S_BOOT: pc_take_branch=1, pc_stall=0, if_flush=1. The redirect is never blocked by pipe_stall.
- Otherwise: pc_take_branch=0. pc_stall=0 only on the advance cycle (S_HOLD & !pipe_stall & !redir), else 1.
- S_REQ:
  - imem_req_valid = !redir.
  - On accept -> S_WAIT.
  - On redir, remain in S_REQ.
- S_WAIT:
  - rsp_valid & !drop_q & !redir: capture if_instr<=rsp_data and if_pc<=pc, then -> S_HOLD.
  - rsp_valid & (drop_q | redir): discard, clear drop_q, -> S_REQ.
  - redir without rsp_valid: drop_q<=1, stay in S_WAIT.
- S_HOLD:
  - if_valid=1.
  - !pipe_stall & !redir: advance, -> S_REQ.
  - redir: discard the held instruction, -> S_REQ.
- Latency: accept at cycle N, response at cycle N+k, if_valid from N+k+1. Minimum of 3 cycles per instruction, no speculation.
- Protocol rules: imem_rsp_valid outside S_WAIT is illegal (assertion). Requests are never retracted once valid unless redir.
- Reset mid-operation: any outstanding response is ignored because state=S_BOOT. The memory side must also reset.

Optional Feature:
FETCH_SEQ_PERF_EN: adds 32-bit saturating counters perf_redirects, perf_stall_cycles (S_HOLD & pipe_stall) and perf_dropped_rsp, exposed as output ports and zeroed on reset. Without the macro, these ports and counters are absent.

Decomposition:
- Package fetch_pkg: state enum fetch_state_e, redirect-source enum, RESET_ADDR default, INSTR_NOP constant.
- Sub-module redirect_prio_sel: combinational priority select plus target alignment. The FSM stays in fetch_sequencer.

Test Plan:
- Reset, then imem with 1-cycle response of data 32'h0000_0013 -> if_valid with if_pc=0, then next request addr 4; pc increments by 4 every 3 cycles.
- pipe_stall held 5 cycles during S_HOLD -> if_instr/if_pc stable, pc_stall=1 throughout, advance on the cycle after release.
- ex_redir_valid target 32'h100 while in S_WAIT, response 2 cycles later -> response discarded, if_flush pulse, next req addr 32'h100.
- trap (32'h80), ex (32'h200) and id (32'h300) in the same cycle -> pc_branch_target=32'h80, the others ignored.
- Redirect coinciding with rsp_valid -> no if_valid, drop_q stays 0, next req at target.
- Target 32'h103 -> pc_branch_target=32'h100.
